vedic_mult_pipe: RTL and testbench

VEDIC_MULT_PIPE -- requirements
Module: vedic_mult_pipe

---
 rtl/vedic_mult_pipe.sv | 181 ++++++++++++++++++
 tb/tb_vedic_mult_pipe.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vedic_mult_pipe.sv
// ---------------------------------------------------------------------------
// vedic_mult_pipe
//   Three-stage pipelined signed/unsigned multiplier built from a recursive
//   Vedic (urdhva-tiryagbhyam) multiplier tree.
//
//   Ports
//     clk        rising-edge clock
//     rst        synchronous active-high reset
//     in_valid   operand pair present on a/b/is_signed
//     in_ready   block accepts operands this cycle
//     a, b       WIDTH-bit multiplicand / multiplier
//     is_signed  1 = two's complement operands, 0 = unsigned
//     out_valid  product present
//     out_ready  downstream accepts the product
//     product    2*WIDTH-bit result (two's complement for signed transactions)
//
//   Stages
//     S1  operand magnitudes and result sign
//     S2  four half-width partial products (lo*lo, hi*lo, lo*hi, hi*hi)
//     S3  recombination and sign restore; drives out_valid/product directly
//
//   Handshake: a transfer happens on a rising edge where valid && ready on
//   the same side. The whole pipeline advances on en = !out_valid ||
//   out_ready and holds otherwise, so in_ready is simply en; bubbles are
//   carried through rather than collapsed. While out_valid && !out_ready,
//   product and out_valid stay stable and no operands are taken.
//
//   WIDTH must be 4, 8, 16 or 32 (a power of two, so every tree level splits
//   evenly down to the 2x2 cell).
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// vedic_mul
//   Combinational N x N unsigned Vedic multiplier, N a power of two >= 2.
//     x, y  N-bit unsigned operands
//     p     2*N-bit unsigned product
//   N = 2 is the crosswise 2x2 cell; larger N splits each operand into
//   halves and combines four half-size products.
// ---------------------------------------------------------------------------
module vedic_mul #(
    parameter int N = 2
) (
    input  logic [N-1:0]   x,
    input  logic [N-1:0]   y,
    output logic [2*N-1:0] p
);

    generate
        if (N == 2) begin : g_cell
            logic t_cross1;
            logic t_cross0;
            logic t_carry;
            logic t_high;

            // Vertical (bit 0), crosswise (bit 1), vertical (bit 2) with carries.
            assign t_cross1 = x[1] & y[0];
            assign t_cross0 = x[0] & y[1];
            assign t_carry  = t_cross1 & t_cross0;
            assign t_high   = x[1] & y[1];

            assign p[0] = x[0] & y[0];
            assign p[1] = t_cross1 ^ t_cross0;
            assign p[2] = t_high ^ t_carry;
            assign p[3] = t_high & t_carry;
        end else begin : g_tree
            localparam int H = N / 2;

            logic [N-1:0] p_ll;
            logic [N-1:0] p_hl;
            logic [N-1:0] p_lh;
            logic [N-1:0] p_hh;

            vedic_mul #(.N(H)) u_ll (.x(x[H-1:0]), .y(y[H-1:0]), .p(p_ll));
            vedic_mul #(.N(H)) u_hl (.x(x[N-1:H]), .y(y[H-1:0]), .p(p_hl));
            vedic_mul #(.N(H)) u_lh (.x(x[H-1:0]), .y(y[N-1:H]), .p(p_lh));
            vedic_mul #(.N(H)) u_hh (.x(x[N-1:H]), .y(y[N-1:H]), .p(p_hh));

            assign p = {{N{1'b0}}, p_ll}
                     + {{H{1'b0}}, p_hl, {H{1'b0}}}
                     + {{H{1'b0}}, p_lh, {H{1'b0}}}
                     + {p_hh, {N{1'b0}}};
        end
    endgenerate

endmodule

module vedic_mult_pipe #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 is_signed,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product
);

    localparam int HALF = WIDTH / 2;

    // Magnitude of an operand. The most negative value maps to 2^(WIDTH-1),
    // which still fits as a WIDTH-bit unsigned number.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x,
                                                   input logic             sgn);
        return (sgn && x[WIDTH-1]) ? -x : x;
    endfunction

    logic en;

    // S1 registers
    logic             s1_valid;
    logic [WIDTH-1:0] s1_mag_a;
    logic [WIDTH-1:0] s1_mag_b;
    logic             s1_neg;

    // S2 registers
    logic             s2_valid;
    logic [WIDTH-1:0] s2_ll;
    logic [WIDTH-1:0] s2_hl;
    logic [WIDTH-1:0] s2_lh;
    logic [WIDTH-1:0] s2_hh;
    logic             s2_neg;

    // Combinational partial products between S1 and S2
    logic [WIDTH-1:0] pp_ll;
    logic [WIDTH-1:0] pp_hl;
    logic [WIDTH-1:0] pp_lh;
    logic [WIDTH-1:0] pp_hh;

    // Combinational recombination between S2 and S3
    logic [2*WIDTH-1:0] sum;

    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    vedic_mul #(.N(HALF)) u_pp_ll (.x(s1_mag_a[HALF-1:0]),     .y(s1_mag_b[HALF-1:0]),     .p(pp_ll));
    vedic_mul #(.N(HALF)) u_pp_hl (.x(s1_mag_a[WIDTH-1:HALF]), .y(s1_mag_b[HALF-1:0]),     .p(pp_hl));
    vedic_mul #(.N(HALF)) u_pp_lh (.x(s1_mag_a[HALF-1:0]),     .y(s1_mag_b[WIDTH-1:HALF]), .p(pp_lh));
    vedic_mul #(.N(HALF)) u_pp_hh (.x(s1_mag_a[WIDTH-1:HALF]), .y(s1_mag_b[WIDTH-1:HALF]), .p(pp_hh));

    assign sum = {{WIDTH{1'b0}}, s2_ll}
               + {{HALF{1'b0}}, s2_hl, {HALF{1'b0}}}
               + {{HALF{1'b0}}, s2_lh, {HALF{1'b0}}}
               + {s2_hh, {WIDTH{1'b0}}};

    // Valid bits and the output product: cleared by reset, shift on en.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            out_valid <= 1'b0;
            product   <= '0;
        end else if (en) begin
            s1_valid  <= in_valid;
            s2_valid  <= s1_valid;
            out_valid <= s2_valid;
            // Negating a zero sum yields zero, so -0 needs no special case.
            product   <= s2_neg ? -sum : sum;
        end
    end

    // Remaining datapath registers carry no reset; their contents only
    // matter alongside a set valid bit.
    always_ff @(posedge clk) begin
        if (en) begin
            s1_mag_a <= magnitude(a, is_signed);
            s1_mag_b <= magnitude(b, is_signed);
            s1_neg   <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);

            s2_ll    <= pp_ll;
            s2_hl    <= pp_hl;
            s2_lh    <= pp_lh;
            s2_hh    <= pp_hh;
            s2_neg   <= s1_neg;
        end
    end

endmodule

// File: tb/tb_vedic_mult_pipe.sv
// ---------------------------------------------------------------------------
// tb_vedic_mult_pipe
//   Three instances (WIDTH 8, 16, 4) share clock and reset. Each has a
//   negedge scoreboard: a reference product is pushed when a transfer is
//   seen on the input side and popped/compared when one is seen on the
//   output side. All inputs change 1 time unit after a rising edge.
// ---------------------------------------------------------------------------
module tb_vedic_mult_pipe;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    // WIDTH = 8 instance
    logic        in_valid8 = 1'b0, in_ready8, sg8 = 1'b0, out_valid8, out_ready8 = 1'b1;
    logic [7:0]  a8 = '0, b8 = '0;
    logic [15:0] product8;
    // WIDTH = 16 instance
    logic        in_valid16 = 1'b0, in_ready16, sg16 = 1'b0, out_valid16, out_ready16 = 1'b1;
    logic [15:0] a16 = '0, b16 = '0;
    logic [31:0] product16;
    // WIDTH = 4 instance
    logic        in_valid4 = 1'b0, in_ready4, sg4 = 1'b0, out_valid4, out_ready4 = 1'b1;
    logic [3:0]  a4 = '0, b4 = '0;
    logic [7:0]  product4;

    vedic_mult_pipe #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .is_signed(sg8), .out_valid(out_valid8),
        .out_ready(out_ready8), .product(product8)
    );
    vedic_mult_pipe #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
        .a(a16), .b(b16), .is_signed(sg16), .out_valid(out_valid16),
        .out_ready(out_ready16), .product(product16)
    );
    vedic_mult_pipe #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4), .is_signed(sg4), .out_valid(out_valid4),
        .out_ready(out_ready4), .product(product4)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference multiply via sign-extended integer arithmetic, truncated to 2*w bits.
    function automatic logic [31:0] ref_mul(input logic [15:0] av, input logic [15:0] bv,
                                            input int w, input logic sv);
        longint x, y, p, one;
        one = 1;
        x = longint'(av) & ((one << w) - 1);
        y = longint'(bv) & ((one << w) - 1);
        if (sv && av[w-1]) x = x - (one << w);
        if (sv && bv[w-1]) y = y - (one << w);
        p = (x * y) & ((one << (2 * w)) - 1);
        return 32'(p);
    endfunction

    // ---------------- scoreboards ----------------
    logic [31:0] exp8_q[$], exp16_q[$], exp4_q[$];
    logic [15:0] got8_q[$];
    int          acc_cyc8[$], out_cyc8[$];
    int          cyc8 = 0, n_out16 = 0, n_out4 = 0;

    always @(negedge clk) begin
        cyc8++;
        if (rst) begin
            exp8_q.delete();
        end else begin
            if (out_valid8 && out_ready8) begin
                got8_q.push_back(product8);
                out_cyc8.push_back(cyc8);
                if (exp8_q.size() == 0) check("dut8_unexpected_output", 32'd1, 32'd0);
                else check("dut8_product", {16'h0, product8}, exp8_q.pop_front());
            end
            if (in_valid8 && in_ready8) begin
                exp8_q.push_back(ref_mul({8'h0, a8}, {8'h0, b8}, 8, sg8));
                acc_cyc8.push_back(cyc8);
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            exp16_q.delete();
        end else begin
            if (out_valid16 && out_ready16) begin
                n_out16++;
                if (exp16_q.size() == 0) check("dut16_unexpected_output", 32'd1, 32'd0);
                else check("dut16_product", product16, exp16_q.pop_front());
            end
            if (in_valid16 && in_ready16) exp16_q.push_back(ref_mul(a16, b16, 16, sg16));
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            exp4_q.delete();
        end else begin
            if (out_valid4 && out_ready4) begin
                n_out4++;
                if (exp4_q.size() == 0) check("dut4_unexpected_output", 32'd1, 32'd0);
                else check("dut4_product", {24'h0, product4}, exp4_q.pop_front());
            end
            if (in_valid4 && in_ready4) exp4_q.push_back(ref_mul({12'h0, a4}, {12'h0, b4}, 4, sg4));
        end
    end

    // Random downstream back-pressure for the WIDTH = 16 stream.
    logic rnd16 = 1'b0;
    always @(posedge clk) begin
        #1;
        if (rnd16) out_ready16 = ($urandom_range(0, 3) != 0);
    end

    // ---------------- driver ----------------
    // Called 1 unit after a rising edge; returns 1 unit after the accepting edge.
    task automatic send(input int which, input logic [15:0] av, input logic [15:0] bv,
                        input logic sv);
        logic acc;
        int   guard;
        case (which)
            8:       begin in_valid8 = 1'b1;  a8 = av[7:0];  b8 = bv[7:0];  sg8 = sv;  end
            16:      begin in_valid16 = 1'b1; a16 = av;      b16 = bv;      sg16 = sv; end
            default: begin in_valid4 = 1'b1;  a4 = av[3:0];  b4 = bv[3:0];  sg4 = sv;  end
        endcase
        acc   = 1'b0;
        guard = 0;
        while (!acc) begin
            @(negedge clk);
            case (which)
                8:       acc = in_ready8;
                16:      acc = in_ready16;
                default: acc = in_ready4;
            endcase
            @(posedge clk); #1;
            guard++;
            if (!acc && guard > 1000) begin
                check("send_timeout", 32'd0, 32'd1);
                break;
            end
        end
        case (which)
            8:       in_valid8 = 1'b0;
            16:      in_valid16 = 1'b0;
            default: in_valid4 = 1'b0;
        endcase
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    function automatic logic [15:0] pick16();
        case ($urandom_range(0, 7))
            0:       return 16'h8000;
            1:       return 16'h7FFF;
            2:       return 16'hFFFF;
            3:       return 16'h0000;
            default: return 16'($urandom_range(0, 65535));
        endcase
    endfunction

    logic [15:0] exp_seq[4];
    int          seen;
    int          guard;

    initial begin
        // ---- reset, with operands offered during reset ----
        in_valid8 = 1'b1; a8 = 8'd5; b8 = 8'd5;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid8 = 1'b0;
        check("reset_out_valid8", {31'h0, out_valid8}, 32'd0);
        check("reset_product8", {16'h0, product8}, 32'd0);
        check("reset_in_ready8", {31'h0, in_ready8}, 32'd1);
        check("reset_out_valid16", {31'h0, out_valid16}, 32'd0);
        check("reset_out_valid4", {31'h0, out_valid4}, 32'd0);
        seen = 0;
        repeat (5) begin
            step();
            if (out_valid8) seen++;
        end
        check("reset_no_phantom_output", seen, 0);

        // ---- single most-negative product, latency ----
        acc_cyc8.delete(); out_cyc8.delete(); got8_q.delete();
        send(8, 16'h0080, 16'h0080, 1'b1);
        check("latency_s1_idle", {31'h0, out_valid8}, 32'd0);
        step();
        check("latency_s2_idle", {31'h0, out_valid8}, 32'd0);
        step();
        check("latency_out_valid", {31'h0, out_valid8}, 32'd1);
        check("neg128_sq_product", {16'h0, product8}, 32'h4000);
        step();
        check("latency_count", out_cyc8.size(), 1);
        if (out_cyc8.size() == 1 && acc_cyc8.size() == 1)
            check("latency_cycles", out_cyc8[0] - acc_cyc8[0], 3);

        // ---- back-to-back mixed-mode stream ----
        acc_cyc8.delete(); out_cyc8.delete(); got8_q.delete();
        exp_seq = '{16'hFFF1, 16'hFE01, 16'hFF81, 16'h0000};
        send(8, 16'h00FD, 16'h0005, 1'b1);   // -3 * 5
        send(8, 16'h00FF, 16'h00FF, 1'b0);   // 255 * 255
        send(8, 16'h007F, 16'h00FF, 1'b1);   // 127 * -1
        send(8, 16'h0000, 16'h00F9, 1'b1);   // 0 * -7
        repeat (6) step();
        check("b2b_count", got8_q.size(), 4);
        if (got8_q.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                check("b2b_product", {16'h0, got8_q[i]}, {16'h0, exp_seq[i]});
                check("b2b_consecutive", out_cyc8[i] - out_cyc8[0], i);
            end
        end

        // ---- stall with a full pipeline ----
        out_ready8 = 1'b0;
        send(8, 16'h0080, 16'h007F, 1'b1);   // -16256
        send(8, 16'h0002, 16'h0003, 1'b1);   // 6
        send(8, 16'h00C8, 16'h0064, 1'b0);   // 20000
        guard = 0;
        while (!out_valid8 && guard < 20) begin
            step();
            guard++;
        end
        check("stall_out_valid_rose", {31'h0, out_valid8}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            check("stall_in_ready", {31'h0, in_ready8}, 32'd0);
            check("stall_out_valid", {31'h0, out_valid8}, 32'd1);
            check("stall_product", {16'h0, product8}, 32'h0000C080);
            step();
        end
        out_ready8 = 1'b1;
        exp_seq = '{16'hC080, 16'h0006, 16'h4E20, 16'h0000};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("drain_out_valid", {31'h0, out_valid8}, 32'd1);
            check("drain_product", {16'h0, product8}, {16'h0, exp_seq[i]});
        end
        step();
        check("drain_empty", {31'h0, out_valid8}, 32'd0);

        // ---- reset with two transactions in flight ----
        send(8, 16'h0011, 16'h0022, 1'b0);
        send(8, 16'h00F0, 16'h0013, 1'b1);
        rst = 1'b1;
        in_valid8 = 1'b1; a8 = 8'd9; b8 = 8'd9;
        step();
        rst = 1'b0;
        in_valid8 = 1'b0;
        check("midreset_out_valid", {31'h0, out_valid8}, 32'd0);
        check("midreset_product", {16'h0, product8}, 32'd0);
        check("midreset_in_ready", {31'h0, in_ready8}, 32'd1);
        seen = 0;
        repeat (6) begin
            step();
            if (out_valid8) seen++;
        end
        check("midreset_discarded", seen, 0);
        check("dut8_queue_empty", exp8_q.size(), 0);

        // ---- WIDTH = 4 exhaustive, both modes ----
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < 16; i++)
                for (int j = 0; j < 16; j++)
                    send(4, 16'(i), 16'(j), s[0]);
        guard = 0;
        while (exp4_q.size() != 0 && guard < 100) begin
            step();
            guard++;
        end
        check("dut4_drain", exp4_q.size(), 0);
        check("dut4_count", n_out4, 512);

        // ---- WIDTH = 16 random stream with random back-pressure ----
        rnd16 = 1'b1;
        for (int n = 0; n < 10000; n++) begin
            if ($urandom_range(0, 4) == 0) step();
            send(16, pick16(), pick16(), 1'($urandom_range(0, 1)));
        end
        rnd16 = 1'b0;
        out_ready16 = 1'b1;
        guard = 0;
        while (exp16_q.size() != 0 && guard < 100) begin
            step();
            guard++;
        end
        check("dut16_drain", exp16_q.size(), 0);
        check("dut16_count", n_out16, 10000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Hard stop in case a handshake wedges beyond every bounded wait.
    initial begin
        #2000000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "simulation time limit reached");
    end

endmodule
